// File: rtl/mdu_hilo.sv
// HI/LO register pair with a multi-cycle multiply/divide unit for the E stage.
// The result is computed at accept, staged, and committed when the busy countdown expires.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_valid,
  input  logic        flush,
  input  logic        start,
  input  logic        immWrite,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q, hi_n, lo_n;
  logic          wr_n;

  logic          is_signed, is_mul, is_div;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, quo_mag, rem_mag;
  logic [63:0]   prod_mag;
  logic [31:0]   hi_c, lo_c;
  logic          wr_c;
  logic [CW-1:0] cyc_c;

  // Signed ops work on magnitudes and fix the signs afterwards, which keeps
  // 0x80000000 / -1 well defined (the negated quotient wraps back to 0x80000000).
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    a_neg     = is_signed & A[31];
    b_neg     = is_signed & B[31];
    a_mag     = a_neg ? (32'd0 - A) : A;
    b_mag     = b_neg ? (32'd0 - B) : B;
    prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
    quo_mag   = 32'd0;
    rem_mag   = 32'd0;
    if (b_mag != 32'd0) begin
      quo_mag = a_mag / b_mag;
      rem_mag = a_mag % b_mag;
    end
    hi_c  = 32'd0;
    lo_c  = 32'd0;
    wr_c  = 1'b0;
    cyc_c = CW'(MULT_CYCLES);
    if (is_mul) begin
      {hi_c, lo_c} = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;
      wr_c         = 1'b1;
    end else if (is_div) begin
      lo_c  = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
      hi_c  = a_neg ? (32'd0 - rem_mag) : rem_mag;
      wr_c  = (B != 32'd0);
      cyc_c = CW'(DIV_CYCLES);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      hi_n   <= '0;
      lo_n   <= '0;
      wr_n   <= 1'b0;
    end else if (busy_q) begin
      // An in-flight op is older than anything in E, so flush and new commands are ignored.
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy_q <= 1'b0;
        if (wr_n) begin
          hi_q <= hi_n;
          lo_q <= lo_n;
        end
      end
    end else if (E_valid && !flush) begin
      if (start) begin
        if (is_mul || is_div) begin
          hi_n   <= hi_c;
          lo_n   <= lo_c;
          wr_n   <= wr_c;
          cnt    <= cyc_c;
          busy_q <= 1'b1;
        end
      end else if (immWrite) begin
        if (op == OP_MTHI) hi_q <= A;
        else if (op == OP_MTLO) lo_q <= A;
      end
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: mul/div expectations go through a scoreboard
// queue checked by a monitor on each busy falling edge.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_valid, flush, start, immWrite;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_valid(E_valid), .flush(flush),
    .start(start), .immWrite(immWrite), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   viol  = 0;
  int   both  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: counts busy cycles and compares HI/LO when busy drops.
  int   mon_cnt  = 0;
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      q.delete();
      mon_cnt  = 0;
      mon_prev = 1'b0;
    end else begin
      if (busy) begin
        mon_cnt++;
      end else if (mon_prev) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check({e.name, "_hi"}, {32'd0, HI}, {32'd0, e.hi});
          check({e.name, "_lo"}, {32'd0, LO}, {32'd0, e.lo});
          check({e.name, "_len"}, 64'(mon_cnt), 64'(e.len));
        end
        mon_cnt = 0;
      end
      mon_prev = busy;
    end
  end

  // Protocol watch: commands issued while busy, and start with immWrite together.
  always @(posedge clk) begin
    if (reset && E_valid && busy && (start || immWrite)) viol++;
    if (E_valid && start && immWrite) both++;
  end

  task automatic issue(input logic s, input logic imw, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ev, input logic fl);
    @(negedge clk);
    start = s; immWrite = imw; op = o; A = a; B = b; E_valid = ev; flush = fl;
    @(negedge clk);
    start = 1'b0; immWrite = 1'b0; E_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ehi, input logic [31:0] elo, input int len,
                    input string name);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.len = len; e.name = name;
    q.push_back(e);
    issue(1'b1, 1'b0, o, a, b, 1'b1, 1'b0);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] a, input logic ev, input logic fl);
    issue(1'b0, 1'b1, o, a, 32'd0, ev, fl);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q.size() != 0) && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("idle_timeout", 64'(n >= 60), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; E_valid = 1'b0; flush = 1'b0; start = 1'b0; immWrite = 1'b0;
    op = 3'd0; A = 32'd0; B = 32'd0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {63'd0, busy}, 64'd0);

    md(3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult");
    wait_idle();
    md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, "multu");
    wait_idle();
    md(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div");
    wait_idle();

    mt(3'd4, 32'h11, 1'b1, 1'b0);
    check("mthi_11", {32'd0, HI}, 64'h11);
    mt(3'd5, 32'h22, 1'b1, 1'b0);
    check("mtlo_22", {32'd0, LO}, 64'h22);
    check("mt_busy", {63'd0, busy}, 64'd0);
    md(3'd3, 32'd7, 32'd0, 32'h11, 32'h22, 10, "divu_by0");
    wait_idle();

    mt(3'd4, 32'h1234, 1'b1, 1'b0);
    check("mthi_1234", {32'd0, HI}, 64'h1234);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    mt(3'd4, 32'h5555, 1'b1, 1'b1);
    check("mthi_flush", {32'd0, HI}, 64'h1234);
    mt(3'd4, 32'h6666, 1'b0, 1'b0);
    check("mthi_invalid", {32'd0, HI}, 64'h1234);
    mt(3'd5, 32'h7777, 1'b1, 1'b1);
    check("mtlo_flush", {32'd0, LO}, 64'h22);

    md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, "div_ovf");
    wait_idle();
    md(3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 10, "div_neg_b");
    wait_idle();

    // New command while a DIV is in flight: must be ignored entirely.
    md(3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 10, "div_ignore");
    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'd6; B = 32'd7; E_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; E_valid = 1'b0; flush = 1'b0;
    wait_idle();

    // Async reset in the middle of a DIV: outputs clear at once, no completion.
    issue(1'b1, 1'b0, 3'd2, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hi", {32'd0, HI}, 64'd0);
    check("midrst_lo", {32'd0, LO}, 64'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("after_rst_busy", {63'd0, busy}, 64'd0);
    md(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5, "mult_6x7");
    wait_idle();

    check("busy_cmd_count", 64'(viol), 64'd1);
    check("start_imm_both", 64'(both), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
